adaptive_threshold_filter: RTL and testbench

Parametrised, pipelined successor to the 4-bit RGB threshold filter, placed between the OV7670 capture or format stage and the frame buffer / VGA path.
- Computes per-pixel luminance from a valid-qualified RGB stream.
- Outputs one of four modes: binary, inverted binary, grayscale or bypass.
- Threshold is either a static register value or an automatic value derived from the previous frame's luminance min/max.

---
 rtl/adaptive_threshold_filter.sv | 180 ++++++++++++++++++
 tb/tb_adaptive_threshold_filter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/adaptive_threshold_filter.sv
// Pixel luminance threshold filter: binary / inverted / grayscale / bypass.
// Latency 2 cycles, no backpressure. Optional macro THRESH_HYST_EN adds per-frame hysteresis.
module adaptive_threshold_filter #(
    parameter int COLOR_W    = 4,
    parameter int DEF_THRESH = 2 ** (COLOR_W - 1),
    parameter int HYST       = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_valid,
    input  logic               i_sof,
    input  logic [COLOR_W-1:0] i_r,
    input  logic [COLOR_W-1:0] i_g,
    input  logic [COLOR_W-1:0] i_b,
    input  logic [1:0]         i_mode,
    input  logic               i_auto,
    input  logic [COLOR_W-1:0] i_thresh,
    output logic               o_valid,
    output logic               o_sof,
    output logic [COLOR_W-1:0] o_r,
    output logic [COLOR_W-1:0] o_g,
    output logic [COLOR_W-1:0] o_b,
    output logic [COLOR_W-1:0] o_thresh
);

    localparam logic [COLOR_W-1:0] DEF_THR = COLOR_W'(DEF_THRESH);

    logic [COLOR_W+1:0] sum;
    logic [COLOR_W-1:0] luma_in;
    logic [COLOR_W:0]   mid_sum;
    logic [COLOR_W-1:0] auto_new;

    logic               s1_valid;
    logic               s1_sof;
    logic [COLOR_W-1:0] s1_luma;
    logic [COLOR_W-1:0] s1_r;
    logic [COLOR_W-1:0] s1_g;
    logic [COLOR_W-1:0] s1_b;

    logic [1:0]         sh_mode;
    logic               sh_auto;
    logic [COLOR_W-1:0] sh_thresh;

    logic [COLOR_W-1:0] stat_min;
    logic [COLOR_W-1:0] stat_max;
    logic               frame_seen;
    logic [COLOR_W-1:0] auto_thr;

    logic [COLOR_W-1:0] thr;
    logic               above;
    logic [COLOR_W-1:0] mux_r;
    logic [COLOR_W-1:0] mux_g;
    logic [COLOR_W-1:0] mux_b;

    always_comb begin
        sum      = {2'b00, i_r} + {1'b0, i_g, 1'b0} + {2'b00, i_b};
        luma_in  = COLOR_W'(sum >> 2);
        mid_sum  = {1'b0, stat_min} + {1'b0, stat_max};
        auto_new = COLOR_W'(mid_sum >> 1);
    end

    // Stage 1: luma, delayed raw pixel, shadow controls and frame statistics
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid   <= 1'b0;
            s1_sof     <= 1'b0;
            s1_luma    <= '0;
            s1_r       <= '0;
            s1_g       <= '0;
            s1_b       <= '0;
            sh_mode    <= 2'd0;
            sh_auto    <= 1'b0;
            sh_thresh  <= DEF_THR;
            stat_min   <= '0;
            stat_max   <= '0;
            frame_seen <= 1'b0;
            auto_thr   <= DEF_THR;
        end else begin
            s1_valid <= i_valid;
            if (i_valid) begin
                s1_sof  <= i_sof;
                s1_luma <= luma_in;
                s1_r    <= i_r;
                s1_g    <= i_g;
                s1_b    <= i_b;
                if (i_sof) begin
                    sh_mode    <= i_mode;
                    sh_auto    <= i_auto;
                    sh_thresh  <= i_thresh;
                    if (frame_seen)
                        auto_thr <= auto_new;
                    stat_min   <= luma_in;
                    stat_max   <= luma_in;
                    frame_seen <= 1'b1;
                end else if (frame_seen) begin
                    if (luma_in < stat_min)
                        stat_min <= luma_in;
                    if (luma_in > stat_max)
                        stat_max <= luma_in;
                end
            end
        end
    end

    assign thr = sh_auto ? auto_thr : sh_thresh;

`ifdef THRESH_HYST_EN
    localparam logic [COLOR_W:0] HYST_V = (COLOR_W + 1)'(HYST);

    logic               hyst_b;
    logic               b_cur;
    logic [COLOR_W:0]   hi_w;
    logic [COLOR_W-1:0] hi;
    logic [COLOR_W-1:0] lo;

    // Band edges saturate so thr near 0 or all-ones stays meaningful
    always_comb begin
        hi_w  = {1'b0, thr} + HYST_V;
        hi    = hi_w[COLOR_W] ? '1 : hi_w[COLOR_W-1:0];
        lo    = ({1'b0, thr} < HYST_V) ? '0 : COLOR_W'({1'b0, thr} - HYST_V);
        b_cur = s1_sof ? 1'b0 : hyst_b;
        above = b_cur ? !(s1_luma < lo) : (s1_luma > hi);
    end

    always_ff @(posedge clk) begin
        if (reset)
            hyst_b <= 1'b0;
        else if (s1_valid)
            hyst_b <= above;
    end
`else
    assign above = s1_luma > thr;
`endif

    always_comb begin
        mux_r = {COLOR_W{above}};
        mux_g = {COLOR_W{above}};
        mux_b = {COLOR_W{above}};
        case (sh_mode)
            2'd1: begin
                mux_r = {COLOR_W{~above}};
                mux_g = {COLOR_W{~above}};
                mux_b = {COLOR_W{~above}};
            end
            2'd2: begin
                mux_r = s1_luma;
                mux_g = s1_luma;
                mux_b = s1_luma;
            end
            2'd3: begin
                mux_r = s1_r;
                mux_g = s1_g;
                mux_b = s1_b;
            end
            default: ;
        endcase
    end

    // Stage 2: output register
    always_ff @(posedge clk) begin
        if (reset) begin
            o_valid  <= 1'b0;
            o_sof    <= 1'b0;
            o_r      <= '0;
            o_g      <= '0;
            o_b      <= '0;
            o_thresh <= '0;
        end else begin
            o_valid <= s1_valid;
            if (s1_valid) begin
                o_sof    <= s1_sof;
                o_r      <= mux_r;
                o_g      <= mux_g;
                o_b      <= mux_b;
                o_thresh <= thr;
            end
        end
    end

endmodule

// File: tb/tb_adaptive_threshold_filter.sv
// Directed-vector bench for adaptive_threshold_filter with COLOR_W = 4.
module tb_adaptive_threshold_filter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       i_valid = 1'b0;
    logic       i_sof = 1'b0;
    logic [3:0] i_r = '0, i_g = '0, i_b = '0;
    logic [1:0] i_mode = 2'd0;
    logic       i_auto = 1'b0;
    logic [3:0] i_thresh = 4'd8;
    logic       o_valid, o_sof;
    logic [3:0] o_r, o_g, o_b, o_thresh;

    int checks = 0;
    int errors = 0;
    logic [15:0] q[$];

    adaptive_threshold_filter #(.COLOR_W(4), .DEF_THRESH(8), .HYST(1)) dut (
        .clk(clk), .reset(reset), .i_valid(i_valid), .i_sof(i_sof),
        .i_r(i_r), .i_g(i_g), .i_b(i_b), .i_mode(i_mode), .i_auto(i_auto),
        .i_thresh(i_thresh), .o_valid(o_valid), .o_sof(o_sof),
        .o_r(o_r), .o_g(o_g), .o_b(o_b), .o_thresh(o_thresh)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (o_valid)
            q.push_back({o_r, o_g, o_b, o_thresh});
    end

    task automatic px(input logic s, input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
        i_valid = 1'b1;
        i_sof = s;
        i_r = r;
        i_g = g;
        i_b = b;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_sof = 1'b0;
    endtask

    task automatic idle(input int n);
        i_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        q.delete();
    endtask

    task automatic check_queue(input string name, input logic [15:0] exp_v[], input int n);
        checks++;
        if (q.size() != n) begin
            errors++;
            $display("FAIL %s count: got %0d outputs, expected %0d", name, q.size(), n);
        end else begin
            for (int k = 0; k < n; k++) begin
                checks++;
                if (q[k] !== exp_v[k]) begin
                    errors++;
                    $display("FAIL %s[%0d]: got rgbt=%h expected %h", name, k, q[k], exp_v[k]);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle(2);
        checks++;
        if ({o_valid, o_sof, o_r, o_g, o_b, o_thresh} !== 18'd0) begin
            errors++;
            $display("FAIL reset_state: got %h expected 0", {o_valid, o_sof, o_r, o_g, o_b, o_thresh});
        end
        reset = 1'b0;
        q.delete();
    endtask

    task automatic test_static_binary();
        i_mode = 2'd0; i_auto = 1'b0; i_thresh = 4'd8;
        px(1'b1, 4'h9, 4'h9, 4'h9);
        checks++;
        if (o_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: o_valid=%b expected 0", o_valid);
        end
        px(1'b0, 4'h8, 4'h8, 4'h8);
        checks++;
        if ({o_valid, o_sof, o_r, o_g, o_b, o_thresh} !== {2'b11, 16'hFFF8}) begin
            errors++;
            $display("FAIL bin_luma9: got %h expected %h", {o_valid, o_sof, o_r, o_g, o_b, o_thresh}, {2'b11, 16'hFFF8});
        end
        idle(1);
        checks++;
        if ({o_valid, o_sof, o_r, o_g, o_b, o_thresh} !== {2'b10, 16'h0008}) begin
            errors++;
            $display("FAIL bin_luma8: got %h expected %h", {o_valid, o_sof, o_r, o_g, o_b, o_thresh}, {2'b10, 16'h0008});
        end
        idle(1);
        checks++;
        if (o_valid !== 1'b0) begin
            errors++;
            $display("FAIL valid_drop: o_valid=%b expected 0", o_valid);
        end
        q.delete();
    endtask

    task automatic test_modes();
        logic [15:0] e[] = '{16'hFFF8, 16'h7778, 16'h46C8, 16'h000F};
        q.delete();
        i_auto = 1'b0; i_thresh = 4'd8;
        i_mode = 2'd1; px(1'b1, 4'hF, 4'h0, 4'hF);
        i_mode = 2'd2; px(1'b1, 4'h4, 4'h6, 4'hC);
        i_mode = 2'd3; px(1'b1, 4'h4, 4'h6, 4'hC);
        i_mode = 2'd0; i_thresh = 4'hF; px(1'b1, 4'hF, 4'hF, 4'hF);
        idle(3);
        check_queue("modes", e, 4);
    endtask

    task automatic test_auto();
        logic [15:0] e[] = '{16'h0008, 16'hFFF8, 16'h0008, 16'hFFF8, 16'h0008, 16'h0005, 16'hFFF3};
        do_reset();
        i_mode = 2'd0; i_auto = 1'b1; i_thresh = 4'd3;
        px(1'b1, 4'h2, 4'h2, 4'h2);
        px(1'b0, 4'hE, 4'hE, 4'hE);
        px(1'b0, 4'h6, 4'h6, 4'h6);
        px(1'b1, 4'h9, 4'h9, 4'h9);
        px(1'b0, 4'h1, 4'h1, 4'h1);
        px(1'b1, 4'h3, 4'h3, 4'h3);
        px(1'b1, 4'hA, 4'hA, 4'hA);
        idle(3);
        check_queue("auto", e, 7);
    endtask

    task automatic test_midframe_mode();
        logic [15:0] e[] = '{16'hFFF8, 16'hFFF8, 16'h0008, 16'h7772};
        q.delete();
        i_mode = 2'd0; i_auto = 1'b0; i_thresh = 4'd8;
        px(1'b1, 4'h9, 4'h9, 4'h9);
        i_mode = 2'd2; i_thresh = 4'd2;
        px(1'b0, 4'h9, 4'h9, 4'h9);
        px(1'b0, 4'h4, 4'h6, 4'hC);
        px(1'b1, 4'h4, 4'h6, 4'hC);
        idle(3);
        check_queue("midframe", e, 4);
    endtask

    task automatic test_gaps_and_reset();
        logic       v[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic       s[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [3:0] d[6] = '{4'h5, 4'h0, 4'hF, 4'h7, 4'h0, 4'h8};
        logic [15:0] e[] = '{16'h0008};
        do_reset();
        i_mode = 2'd0; i_auto = 1'b1;
        for (int k = 0; k < 6; k++) begin
            i_valid = v[k]; i_sof = s[k];
            i_r = d[k]; i_g = d[k]; i_b = d[k];
            @(posedge clk);
            #1;
            if (k >= 1) begin
                checks++;
                if (o_valid !== v[k-1]) begin
                    errors++;
                    $display("FAIL gap_valid[%0d]: o_valid=%b expected %b", k - 1, o_valid, v[k-1]);
                end
            end
        end
        i_valid = 1'b0; i_sof = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({o_valid, o_r, o_g, o_b, o_thresh} !== {1'b1, 16'hFFF6}) begin
            errors++;
            $display("FAIL gap_stats: got %h expected %h", {o_valid, o_r, o_g, o_b, o_thresh}, {1'b1, 16'hFFF6});
        end
        px(1'b0, 4'h2, 4'h2, 4'h2);
        i_valid = 1'b1; i_r = 4'h9; i_g = 4'h9; i_b = 4'h9;
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({o_valid, o_r, o_g, o_b, o_thresh} !== 17'd0) begin
            errors++;
            $display("FAIL midframe_reset: got %h expected 0", {o_valid, o_r, o_g, o_b, o_thresh});
        end
        reset = 1'b0; i_valid = 1'b0;
        q.delete();
        px(1'b1, 4'h7, 4'h7, 4'h7);
        idle(3);
        check_queue("after_reset", e, 1);
    endtask

    task automatic test_hysteresis();
`ifdef THRESH_HYST_EN
        logic [15:0] e[] = '{16'h0008, 16'hFFF8, 16'hFFF8, 16'hFFF8, 16'h0008};
`else
        logic [15:0] e[] = '{16'hFFF8, 16'hFFF8, 16'h0008, 16'h0008, 16'h0008};
`endif
        q.delete();
        i_mode = 2'd0; i_auto = 1'b0; i_thresh = 4'd8;
        px(1'b1, 4'h9, 4'h9, 4'h9);
        px(1'b0, 4'hA, 4'hA, 4'hA);
        px(1'b0, 4'h8, 4'h8, 4'h8);
        px(1'b0, 4'h7, 4'h7, 4'h7);
        px(1'b0, 4'h6, 4'h6, 4'h6);
        idle(3);
        check_queue("hyst", e, 5);
    endtask

    initial begin
        test_reset();
        test_static_binary();
        test_modes();
        test_auto();
        test_midframe_mode();
        test_gaps_and_reset();
        test_hysteresis();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
